// File: rtl/serial_pkg.sv
// Shared types and line constants for the serial transmit path.
// Frame: start bit, WIDTH data bits LSB first, stop bit.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Busy cycles taken by one complete frame.
    function automatic int frame_cycles(input int width, input int clks);
        return (width + 2) * clks;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Word handshake and serial line bundle for serial_tx.
// master drives the word and load; slave owns the line and status.
interface serial_tx_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output load,
        input  ready,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  load,
        output ready,
        output tx,
        output busy,
        output done
    );

endinterface

// File: rtl/bit_timer.sv
// Bit period divider: tick marks the last clock of each bit.
// Counter is held at zero whenever run is low.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLKS_PER_BIT - 1);

    logic [DW-1:0] div;

    assign tick = run && (div == LAST);

    // Count 0..CLKS_PER_BIT-1 while running, wrap at each bit boundary.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in serial-out transmitter with load/ready handshake.
// Every output is a register; ready is kept as the inverse of busy.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input logic      clk,
    input logic      rst_n,
    serial_tx_if.slave bus
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] sh_next;
    logic [IW-1:0]    idx;
    logic             tx_q;
    logic             busy_q;
    logic             ready_q;
    logic             done_q;
    logic             tick;

    assign sh_next   = shreg >> 1;
    assign bus.tx    = tx_q;
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.done  = done_q;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (busy_q),
        .tick (tick)
    );

    // Frame sequencer; the line value for the next cycle is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            idx     <= '0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    tx_q   <= LINE_IDLE;
                    if (bus.load && ready_q) begin
                        shreg   <= bus.data_in;
                        idx     <= '0;
                        state   <= START;
                        tx_q    <= START_BIT;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        idx   <= '0;
                        tx_q  <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= sh_next;
                        if (idx == LAST_BIT) begin
                            state <= STOP;
                            tx_q  <= STOP_BIT;
                        end else begin
                            idx  <= idx + IW'(1);
                            tx_q <= sh_next[0];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state   <= IDLE;
                        tx_q    <= LINE_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: two instances (8b/4clk and 4b/1clk).
// Expected line waveforms are built from the frame rules as bit queues.
module tb_serial_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int vectors = 0;
    int errs = 0;

    bit exp_q[$];

    always #5 clk = ~clk;

    serial_tx_if #(.WIDTH(8)) if_a ();
    serial_tx_if #(.WIDTH(4)) if_b ();

    serial_tx #(
        .WIDTH       (8),
        .CLKS_PER_BIT(4)
    ) u_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_a.slave)
    );

    serial_tx #(
        .WIDTH       (4),
        .CLKS_PER_BIT(1)
    ) u_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_b.slave)
    );

    // Line waveform of one frame: each of start, data LSB first, stop
    // repeated n times.
    function automatic void make_frame(input logic [31:0] d,
                                       input int w, input int n);
        exp_q.delete();
        for (int b = 0; b < w + 2; b++) begin
            bit v;
            if (b == 0) v = 1'b0;
            else if (b == w + 1) v = 1'b1;
            else v = d[b-1];
            for (int r = 0; r < n; r++) exp_q.push_back(v);
        end
    endfunction

    function automatic logic [3:0] obs_a();
        return {if_a.tx, if_a.busy, if_a.ready, if_a.done};
    endfunction

    function automatic logic [3:0] obs_b();
        return {if_b.tx, if_b.busy, if_b.ready, if_b.done};
    endfunction

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0;
        if_a.load = 1'b0;
        if_a.data_in = 8'h00;
        if_b.load = 1'b0;
        if_b.data_in = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = obs_a();
        vectors++;
        if (got !== 4'b1010) begin
            errs++;
            $display("FAIL reset_a got %b exp %b", got, 4'b1010);
        end
        got = obs_b();
        vectors++;
        if (got !== 4'b1010) begin
            errs++;
            $display("FAIL reset_b got %b exp %b", got, 4'b1010);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single(input logic [7:0] d, input string tag);
        logic [3:0] got;
        make_frame(d, 8, 4);
        vectors++;
        if (if_a.ready !== 1'b1) begin
            errs++;
            $display("FAIL %s pre_ready got %b exp 1", tag, if_a.ready);
        end
        if_a.data_in = d;
        if_a.load = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) if_a.load = 1'b0;
            got = obs_a();
            vectors++;
            if (got !== {exp_q[i], 3'b100}) begin
                errs++;
                $display("FAIL %s cyc %0d got %b exp %b",
                         tag, i, got, {exp_q[i], 3'b100});
            end
        end
        @(negedge clk);
        got = obs_a();
        vectors++;
        if (got !== 4'b1011) begin
            errs++;
            $display("FAIL %s done got %b exp %b", tag, got, 4'b1011);
        end
        @(negedge clk);
        got = obs_a();
        vectors++;
        if (got !== 4'b1010) begin
            errs++;
            $display("FAIL %s after got %b exp %b", tag, got, 4'b1010);
        end
    endtask

    task automatic test_load_busy();
        logic [3:0] got;
        make_frame(8'hA5, 8, 4);
        if_a.data_in = 8'hA5;
        if_a.load = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) if_a.load = 1'b0;
            if (i == 9) begin
                if_a.data_in = 8'h3C;
                if_a.load = 1'b1;
            end
            if (i == 10) if_a.load = 1'b0;
            got = obs_a();
            vectors++;
            if (got !== {exp_q[i], 3'b100}) begin
                errs++;
                $display("FAIL load_busy cyc %0d got %b exp %b",
                         i, got, {exp_q[i], 3'b100});
            end
        end
        @(negedge clk);
        got = obs_a();
        vectors++;
        if (got !== 4'b1011) begin
            errs++;
            $display("FAIL load_busy done got %b exp %b", got, 4'b1011);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = obs_a();
            vectors++;
            if (got !== 4'b1010) begin
                errs++;
                $display("FAIL load_busy idle %0d got %b exp %b",
                         i, got, 4'b1010);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        make_frame(8'h01, 8, 4);
        if_a.data_in = 8'h01;
        if_a.load = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) if_a.data_in = 8'hFF;
            got = obs_a();
            vectors++;
            if (got !== {exp_q[i], 3'b100}) begin
                errs++;
                $display("FAIL b2b_first cyc %0d got %b exp %b",
                         i, got, {exp_q[i], 3'b100});
            end
        end
        @(negedge clk);
        got = obs_a();
        vectors++;
        if (got !== 4'b1011) begin
            errs++;
            $display("FAIL b2b_gap got %b exp %b", got, 4'b1011);
        end
        make_frame(8'hFF, 8, 4);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) if_a.load = 1'b0;
            got = obs_a();
            vectors++;
            if (got !== {exp_q[i], 3'b100}) begin
                errs++;
                $display("FAIL b2b_second cyc %0d got %b exp %b",
                         i, got, {exp_q[i], 3'b100});
            end
        end
        @(negedge clk);
        got = obs_a();
        vectors++;
        if (got !== 4'b1011) begin
            errs++;
            $display("FAIL b2b_done got %b exp %b", got, 4'b1011);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        logic [7:0] d;
        d = 8'($urandom);
        make_frame(d, 8, 4);
        if_a.data_in = d;
        if_a.load = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) if_a.load = 1'b0;
            got = obs_a();
            vectors++;
            if (got !== {exp_q[i], 3'b100}) begin
                errs++;
                $display("FAIL rst_mid cyc %0d got %b exp %b",
                         i, got, {exp_q[i], 3'b100});
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        got = obs_a();
        vectors++;
        if (got !== 4'b1010) begin
            errs++;
            $display("FAIL rst_mid edge got %b exp %b", got, 4'b1010);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            got = obs_a();
            vectors++;
            if (got !== 4'b1010) begin
                errs++;
                $display("FAIL rst_mid idle %0d got %b exp %b",
                         i, got, 4'b1010);
            end
        end
        test_single(8'h5A, "rst_mid_5a");
    endtask

    task automatic test_clk1(input logic [3:0] d);
        logic [3:0] got;
        make_frame({28'h0, d}, 4, 1);
        if_b.data_in = d;
        if_b.load = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) if_b.load = 1'b0;
            got = obs_b();
            vectors++;
            if (got !== {exp_q[i], 3'b100}) begin
                errs++;
                $display("FAIL clk1 d=%h cyc %0d got %b exp %b",
                         d, i, got, {exp_q[i], 3'b100});
            end
        end
        @(negedge clk);
        got = obs_b();
        vectors++;
        if (got !== 4'b1011) begin
            errs++;
            $display("FAIL clk1 d=%h done got %b exp %b", d, got, 4'b1011);
        end
        @(negedge clk);
        got = obs_b();
        vectors++;
        if (got !== 4'b1010) begin
            errs++;
            $display("FAIL clk1 d=%h after got %b exp %b", d, got, 4'b1010);
        end
    endtask

    task automatic test_random();
        logic [3:0] got;
        for (int n = 0; n < 6; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                got = obs_a();
                vectors++;
                if (got !== 4'b1010) begin
                    errs++;
                    $display("FAIL rand_gap got %b exp %b", got, 4'b1010);
                end
            end
            test_single(8'($urandom), "rand");
        end
        for (int n = 0; n < 4; n++) begin
            test_clk1(4'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5, "single_a5");
        test_load_busy();
        test_back_to_back();
        test_reset_mid();
        test_clk1(4'b1001);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
